// File: rtl/cordic_pwm_dac.sv
// cordic_pwm_dac
//
// Audio output stage for the CORDIC waveform generator. Signed samples arrive
// over a valid/ready handshake into a one-entry buffer. At every PWM period
// boundary the buffered sample becomes the active duty cycle. The duty cycle
// drives a single registered PWM pin that feeds an external RC filter.
//
// Ports
//   clk1          system clock
//   reset         synchronous, active-high reset
//   sample_in     signed WIDTH-bit sample from the CORDIC path
//   sample_valid  sample_in is valid this cycle
//   sample_ready  buffer is empty; a sample transfers when valid & ready
//   pwm_en        1 = run the carrier, 0 = idle with the output held low
//   underrun_clr  clears the sticky underrun flag
//   pwm_data      registered PWM output
//   period_start  one-cycle pulse whenever a new duty cycle is loaded
//   underrun      sticky flag: a period began while the buffer was empty

module cordic_pwm_dac #(
    parameter int WIDTH    = 12,
    parameter int PWM_BITS = 8,
    parameter int PRESC    = 4
) (
    input  logic             clk1,
    input  logic             reset,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             sample_valid,
    output logic             sample_ready,
    input  logic             pwm_en,
    input  logic             underrun_clr,
    output logic             pwm_data,
    output logic             period_start,
    output logic             underrun
);

    localparam int PRESC_W = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(PRESC - 1);
    localparam logic [PWM_BITS-1:0] CNT_LAST   = '1;
    localparam logic [PWM_BITS-1:0] MIDSCALE   = {1'b1, {(PWM_BITS-1){1'b0}}};

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]          state;
    logic [PRESC_W-1:0]  presc;
    logic [PWM_BITS-1:0] cnt;
    logic [PWM_BITS-1:0] active_duty;
    logic [PWM_BITS-1:0] buf_duty;
    logic                buf_full;

    logic [WIDTH-1:0]    offset_sample;
    logic [PWM_BITS-1:0] sample_duty;
    logic                tick;
    logic                load_start;
    logic                load_wrap;
    logic                load;
    logic                accept;

    // Flipping the sign bit turns two's complement into offset binary, so the
    // most negative sample maps to duty 0 and the most positive to full scale.
    // Only the top PWM_BITS bits fit the carrier resolution.
    assign offset_sample = {~sample_in[WIDTH-1], sample_in[WIDTH-2:0]};
    assign sample_duty   = offset_sample[WIDTH-1 -: PWM_BITS];

    // The sub-resolution bits are dropped on purpose.
    if (PWM_BITS < WIDTH) begin : g_drop_lsbs
        logic unused_sample_lsbs;
        assign unused_sample_lsbs = ^offset_sample[WIDTH-PWM_BITS-1:0];
    end

    assign tick         = (presc == PRESC_LAST);
    assign load_start   = (state == ST_IDLE) && pwm_en;
    assign load_wrap    = (state == ST_RUN) && pwm_en && tick && (cnt == CNT_LAST);
    assign load         = load_start || load_wrap;
    assign accept       = sample_valid && !buf_full;
    assign sample_ready = ~buf_full;

    // Run/idle control and the carrier counters. Leaving RUN aborts the
    // current period. Entering RUN always starts a fresh period from zero.
    always_ff @(posedge clk1) begin
        if (reset) begin
            state <= ST_IDLE;
            presc <= '0;
            cnt   <= '0;
        end else if (state == ST_IDLE) begin
            if (pwm_en) begin
                state <= ST_RUN;
                presc <= '0;
                cnt   <= '0;
            end
        end else begin
            if (!pwm_en) begin
                state <= ST_IDLE;
                presc <= '0;
                cnt   <= '0;
            end else if (tick) begin
                presc <= '0;
                cnt   <= cnt + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

    // One-entry sample buffer and the duty register it feeds. A load and an
    // accept can coincide only when the buffer is empty. In that case the
    // load keeps the old duty, and the new sample waits for the next period.
    always_ff @(posedge clk1) begin
        if (reset) begin
            buf_full    <= 1'b0;
            buf_duty    <= '0;
            active_duty <= MIDSCALE;
        end else begin
            if (load && buf_full) begin
                active_duty <= buf_duty;
                buf_full    <= 1'b0;
            end
            if (accept) begin
                buf_full <= 1'b1;
                buf_duty <= sample_duty;
            end
        end
    end

    // Status flags. Setting underrun takes precedence over clearing it, so an
    // underrun is never lost when the clear lands on the same cycle.
    always_ff @(posedge clk1) begin
        if (reset) begin
            period_start <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            period_start <= load;
            if (load && !buf_full) begin
                underrun <= 1'b1;
            end else if (underrun_clr) begin
                underrun <= 1'b0;
            end
        end
    end

    // PWM comparator. The output is high while the counter is below the duty
    // value. Gating with pwm_en drops the pin on the first disabled cycle.
    always_ff @(posedge clk1) begin
        if (reset) begin
            pwm_data <= 1'b0;
        end else begin
            pwm_data <= (state == ST_RUN) && pwm_en && (cnt < active_duty);
        end
    end

endmodule

// File: tb/tb_cordic_pwm_dac.sv
// tb_cordic_pwm_dac
//
// Directed bench for cordic_pwm_dac. Accepted samples are queued as expected
// duty values. A monitor pops one at every period start. It also checks the
// length and high time of each completed period and tracks the sticky
// underrun flag against its own model.

module tb_cordic_pwm_dac;

    localparam int WIDTH    = 12;
    localparam int PWM_BITS = 8;
    localparam int PRESC    = 2;
    localparam int PERIOD   = (1 << PWM_BITS) * PRESC;
    localparam int BOUND    = 2 * PERIOD + 16;
    localparam int MIDSCALE = 1 << (PWM_BITS - 1);

    logic             clk1;
    logic             reset;
    logic [WIDTH-1:0] sample_in;
    logic             sample_valid;
    logic             sample_ready;
    logic             pwm_en;
    logic             underrun_clr;
    logic             pwm_data;
    logic             period_start;
    logic             underrun;

    int tests_run    = 0;
    int tests_failed = 0;

    int sb[$];
    int exp_active   = MIDSCALE;
    bit exp_underrun = 1'b0;
    bit in_period    = 1'b0;
    int high_acc     = 0;
    int len_acc      = 0;
    int periods      = 0;

    cordic_pwm_dac #(
        .WIDTH    (WIDTH),
        .PWM_BITS (PWM_BITS),
        .PRESC    (PRESC)
    ) dut (
        .clk1         (clk1),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .pwm_en       (pwm_en),
        .underrun_clr (underrun_clr),
        .pwm_data     (pwm_data),
        .period_start (period_start),
        .underrun     (underrun)
    );

    // 100 MHz-style free-running clock
    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    // Offset-binary duty computed arithmetically: shift the range up to
    // non-negative, then keep the top PWM_BITS bits by division.
    function automatic int expected_duty(input int s);
        return (s + (1 << (WIDTH - 1))) / (1 << (WIDTH - PWM_BITS));
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Present a sample and hold it until the buffer takes it. Returns the
    // number of cycles spent waiting for ready.
    task automatic applyStimulus(input int s, output int waited);
        bit accepted;
        accepted     = 1'b0;
        waited       = 0;
        sample_in    = s[WIDTH-1:0];
        sample_valid = 1'b1;
        for (int n = 0; n < BOUND; n++) begin
            if (sample_ready === 1'b1) begin
                accepted = 1'b1;
                break;
            end
            @(negedge clk1);
            waited++;
        end
        @(negedge clk1);
        sample_valid = 1'b0;
        if (accepted) sb.push_back(expected_duty(s));
        checkOutput("accept_timeout", 32'(accepted), 1);
    endtask

    // Advance to the negedge on which the next period_start pulse is visible.
    task automatic wait_period(input string tag);
        bit found;
        found = 1'b0;
        for (int n = 0; n < BOUND; n++) begin
            @(negedge clk1);
            if (period_start === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput(tag, 32'(found), 1);
    endtask

    // Period monitor and underrun model, sampled just after each rising edge
    always @(posedge clk1) begin
        #1;
        if (reset) begin
            sb.delete();
            exp_active   = MIDSCALE;
            exp_underrun = 1'b0;
            in_period    = 1'b0;
        end else begin
            if (in_period) begin
                high_acc += int'(pwm_data);
                len_acc++;
            end
            if (underrun_clr) exp_underrun = 1'b0;
            if (period_start) begin
                periods++;
                if (in_period) begin
                    checkOutput("period_len", len_acc, PERIOD);
                    checkOutput("high_time", high_acc, exp_active * PRESC);
                end
                if (sb.size() > 0) exp_active = sb.pop_front();
                else exp_underrun = 1'b1;
                in_period = 1'b1;
                high_acc  = 0;
                len_acc   = 0;
            end
            if (!pwm_en) in_period = 1'b0;
        end
        checkOutput("underrun_track", 32'(underrun), 32'(exp_underrun));
    end

    initial begin
        int w;
        reset        = 1'b1;
        pwm_en       = 1'b0;
        sample_valid = 1'b0;
        sample_in    = '0;
        underrun_clr = 1'b0;

        // Reset state
        repeat (3) @(negedge clk1);
        checkOutput("rst_pwm_data", 32'(pwm_data), 0);
        checkOutput("rst_ready", 32'(sample_ready), 1);
        checkOutput("rst_underrun", 32'(underrun), 0);
        checkOutput("rst_period_start", 32'(period_start), 0);
        reset = 1'b0;
        @(negedge clk1);
        checkOutput("idle_no_start", 32'(period_start), 0);

        // Handshake: A buffered in idle, B blocked until the first load
        applyStimulus(-2048, w);
        checkOutput("idle_accept_wait", w, 0);
        checkOutput("buf_full_ready", 32'(sample_ready), 0);
        pwm_en = 1'b1;
        applyStimulus(0, w);
        checkOutput("blocked_until_load", w, 1);
        checkOutput("first_load_count", periods, 1);
        checkOutput("b_buffered", 32'(sample_ready), 0);

        // Full-scale sample waits for the second load
        applyStimulus(2047, w);
        checkOutput("wait_second_load", periods, 2);
        wait_period("load3");
        wait_period("load4");
        checkOutput("underrun_set", 32'(underrun), 1);

        // Clear issued in the same cycle as a load that underruns again
        repeat (PERIOD - 1) @(negedge clk1);
        underrun_clr = 1'b1;
        @(negedge clk1);
        checkOutput("clr_vs_load_start", 32'(period_start), 1);
        checkOutput("clr_vs_load", 32'(underrun), 1);
        underrun_clr = 1'b1;
        @(negedge clk1);
        underrun_clr = 1'b0;
        checkOutput("underrun_cleared", 32'(underrun), 0);

        // Abort mid-period at cnt=100 (full-scale duty, so the pin is high)
        repeat (199) @(negedge clk1);
        checkOutput("high_before_abort", 32'(pwm_data), 1);
        pwm_en = 1'b0;
        @(negedge clk1);
        checkOutput("abort_low", 32'(pwm_data), 0);
        checkOutput("abort_no_start", 32'(period_start), 0);
        applyStimulus(1024, w);
        checkOutput("idle_accept_after_abort", w, 0);
        repeat (3) @(negedge clk1);
        checkOutput("idle_low", 32'(pwm_data), 0);

        // Re-enable: immediate load, counter restarts from zero
        pwm_en = 1'b1;
        wait_period("restart_load");
        checkOutput("restart_no_underrun", 32'(underrun), 0);
        @(negedge clk1);
        checkOutput("restart_cnt0_high", 32'(pwm_data), 1);

        // Sample offered in the load cycle with an empty buffer
        repeat (PERIOD - 2) @(negedge clk1);
        checkOutput("sim_ready_before", 32'(sample_ready), 1);
        checkOutput("sim_underrun_before", 32'(underrun), 0);
        sample_in    = 12'hC00;
        sample_valid = 1'b1;
        @(negedge clk1);
        sample_valid = 1'b0;
        sb.push_back(expected_duty(-1024));
        checkOutput("sim_load_start", 32'(period_start), 1);
        checkOutput("sim_underrun", 32'(underrun), 1);
        checkOutput("sim_held", 32'(sample_ready), 0);
        wait_period("held_load");
        checkOutput("held_consumed", 32'(sample_ready), 1);
        wait_period("after_held");

        // Reset in the middle of a running period with a sample buffered
        repeat (300) @(negedge clk1);
        applyStimulus(2047, w);
        checkOutput("mid_accept_wait", w, 0);
        reset = 1'b1;
        repeat (3) @(negedge clk1);
        checkOutput("rst_mid_pwm_data", 32'(pwm_data), 0);
        checkOutput("rst_mid_ready", 32'(sample_ready), 1);
        checkOutput("rst_mid_underrun", 32'(underrun), 0);
        checkOutput("rst_mid_period_start", 32'(period_start), 0);
        reset = 1'b0;
        wait_period("post_reset_load");
        checkOutput("post_reset_underrun", 32'(underrun), 1);
        wait_period("post_reset_period");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
